// File: rtl/tlp_completion_builder.sv
// Completion TLP builder: collects subunit words, emits Cpl/CplD beats.
// Define CPL_PARITY_EN to drive even parity of the DW on out_tlp[34].
module tlp_completion_builder #(
  parameter int          MAX_LEN      = 16,
  parameter int          TIMEOUT      = 255,
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_len,
  input  logic        req_is_read,
  input  logic [15:0] req_id,
  input  logic [7:0]  req_tag,
  input  logic [31:0] sub_data,
  input  logic [3:0]  sub_status,
  output logic        sub_ready,
  output logic [34:0] out_tlp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [9:0]    LMAX  = 10'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [2:0] ST_SC = 3'b000;
  localparam logic [2:0] ST_UR = 3'b001;
  localparam logic [2:0] ST_CA = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_HDR0, S_HDR1, S_HDR2, S_DATA
  } state_t;

  state_t r_state, w_nstate;

  logic [9:0]    r_len;
  logic          r_is_read;
  logic [15:0]   r_id;
  logic [7:0]    r_tag;
  logic [2:0]    r_status;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_ack;
  logic [AW-1:0] r_rd_idx;
  logic [31:0]   r_buf [MAX_LEN];

  logic        w_rej;
  logic        w_cap;
  logic        w_done_cap;
  logic        w_abort;
  logic        w_fire;
  logic        w_cpld;
  logic        w_data_last;
  logic [31:0] w_dw;
  logic        w_sop;
  logic        w_eop;
  logic        w_par;

  assign w_rej = req_is_read &&
                 (req_len == 10'd0 || req_len > LMAX);
  // sub_ready is low in the ack cycle, so a capture needs !r_ack
  assign w_cap = (r_state == S_COLLECT) && !r_ack &&
                 (sub_status == 4'b1000);
  assign w_done_cap = w_cap &&
    (!r_is_read || (10'(r_cnt) + 10'd1 == r_len));
  assign w_abort = (r_state == S_COLLECT) && !w_cap &&
                   (r_tmo == TLAST);
  assign w_fire = out_valid && out_ready;
  assign w_cpld = r_is_read && (r_status == ST_SC);
  assign w_data_last = (10'(r_rd_idx) == r_len - 10'd1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_valid) w_nstate = w_rej ? S_HDR0 : S_COLLECT;
      S_COLLECT:
        if (w_done_cap || w_abort) w_nstate = S_HDR0;
      S_HDR0:
        if (w_fire) w_nstate = S_HDR1;
      S_HDR1:
        if (w_fire) w_nstate = S_HDR2;
      S_HDR2:
        if (w_fire) w_nstate = w_cpld ? S_DATA : S_IDLE;
      S_DATA:
        if (w_fire && w_data_last) w_nstate = S_IDLE;
      default:
        w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len     <= '0;
      r_is_read <= 1'b0;
      r_id      <= '0;
      r_tag     <= '0;
      r_status  <= ST_SC;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_ack     <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_ack <= w_cap;
      if (r_state == S_IDLE && req_valid) begin
        r_len     <= req_len;
        r_is_read <= req_is_read;
        r_id      <= req_id;
        r_tag     <= req_tag;
        r_status  <= w_rej ? ST_UR : ST_SC;
        r_cnt     <= '0;
        r_tmo     <= '0;
        r_rd_idx  <= '0;
      end
      if (r_state == S_COLLECT) begin
        if (w_cap) begin
          r_tmo <= '0;
          if (r_is_read) r_cnt <= r_cnt + CW'(1);
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
        if (w_abort) begin
          r_status <= ST_CA;
          r_cnt    <= '0;
        end
      end
      if (r_state == S_DATA && w_fire)
        r_rd_idx <= r_rd_idx + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap && r_is_read)
      r_buf[r_cnt[AW-1:0]] <= sub_data;
  end

  always_comb begin
    w_dw  = '0;
    w_sop = 1'b0;
    w_eop = 1'b0;
    unique case (r_state)
      S_HDR0: begin
        w_dw  = {w_cpld ? 8'h4A : 8'h0A, 14'd0,
                 w_cpld ? r_len : 10'd0};
        w_sop = 1'b1;
      end
      S_HDR1:
        w_dw = {COMPLETER_ID, r_status, 1'b0,
                w_cpld ? {r_len, 2'b00} : 12'd0};
      S_HDR2: begin
        w_dw  = {r_id, r_tag, 8'h00};
        w_eop = !w_cpld;
      end
      S_DATA: begin
        w_dw  = r_buf[r_rd_idx];
        w_eop = w_data_last;
      end
      default: begin
        w_dw  = '0;
        w_sop = 1'b0;
        w_eop = 1'b0;
      end
    endcase
  end

`ifdef CPL_PARITY_EN
  assign w_par = ^w_dw;
`else
  assign w_par = 1'b0;
`endif

  assign out_tlp   = {w_par, w_eop, w_sop, w_dw};
  assign out_valid = (r_state != S_IDLE) &&
                     (r_state != S_COLLECT);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign sub_ready = (r_state == S_COLLECT) && !r_ack;
endmodule

// File: tb/tb_tlp_completion_builder.sv
// Scoreboard bench for tlp_completion_builder.
// Expected beats are queued at request time; a monitor pops on transfer.
module tb_tlp_completion_builder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_len = '0;
  logic        req_is_read = 1'b0;
  logic [15:0] req_id = '0;
  logic [7:0]  req_tag = '0;
  logic [31:0] sub_data = '0;
  logic [3:0]  sub_status = '0;
  logic        sub_ready;
  logic [34:0] out_tlp;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  int n_tests = 0;
  int n_fail = 0;
  int or_mode = 0;
  logic [34:0] exp_q[$];
  logic [31:0] cur_words[$];
  bit          hold_v = 0;
  logic [34:0] hold_tlp = '0;

  tlp_completion_builder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_is_read(req_is_read),
    .req_id(req_id), .req_tag(req_tag),
    .sub_data(sub_data), .sub_status(sub_status),
    .sub_ready(sub_ready),
    .out_tlp(out_tlp), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic par(input logic [31:0] d);
`ifdef CPL_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: list the completion DWs, then frame them.
  task automatic push_expected(input bit rd, input int len,
                               input logic [15:0] id,
                               input logic [7:0] tag,
                               input bit tmo);
    logic [2:0]  st;
    bit          cpld;
    logic [31:0] dws[$];
    int          n;
    if (rd && (len == 0 || len > 16)) st = 3'b001;
    else if (tmo)                     st = 3'b100;
    else                              st = 3'b000;
    cpld = rd && (st == 3'b000);
    dws.push_back({cpld ? 8'h4A : 8'h0A, 14'd0,
                   10'(cpld ? len : 0)});
    dws.push_back({16'h0100, st, 1'b0, 12'(cpld ? len * 4 : 0)});
    dws.push_back({id, tag, 8'h00});
    if (cpld)
      for (int i = 0; i < len; i++) dws.push_back(cur_words[i]);
    n = dws.size();
    for (int i = 0; i < n; i++)
      exp_q.push_back({par(dws[i]),
                       (i == n - 1) ? 1'b1 : 1'b0,
                       (i == 0) ? 1'b1 : 1'b0, dws[i]});
  endtask

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom);
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", 64'(out_tlp), 64'(hold_tlp));
      end
      hold_v = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_unexpected: got %h expected none",
                     out_tlp);
          end else begin
            chk("beat", 64'(out_tlp), 64'(exp_q.pop_front()));
          end
        end else begin
          hold_v   = 1;
          hold_tlp = out_tlp;
        end
      end
    end
  end

  task automatic issue(input bit rd, input int len,
                       input logic [15:0] id, input logic [7:0] tag,
                       input bit glitch);
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_is_read = rd;
    req_len     = 10'(len);
    req_id      = id;
    req_tag     = tag;
    @(posedge clk); #1;
    if (glitch) begin
      req_is_read = 1'($urandom);
      req_len     = 10'($urandom);
      req_id      = 16'($urandom);
      req_tag     = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic send_words(input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      sub_data   = cur_words[k];
      sub_status = 4'b1000;
      got = 0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (sub_ready) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        chk("capture_wait", 64'(got), 64'd1);
        sub_status = 4'h0;
        return;
      end
      @(posedge clk); #1;
      sub_status = 4'h0;
      sub_data   = $urandom;
      @(negedge clk);
      chk("ack_low", 64'(sub_ready), 64'd0);
      if (k < n - 1) begin
        @(negedge clk);
        chk("ack_release", 64'(sub_ready), 64'd1);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_txn(input bit rd, input int len,
                         input logic [15:0] id, input logic [7:0] tag,
                         input bit tmo, input int orm,
                         input bit glitch);
    bit rej;
    bit ok;
    bit saw;
    int nw;
    rej = rd && (len == 0 || len > 16);
    or_mode = orm;
    push_expected(rd, len, id, tag, tmo);
    issue(rd, len, id, tag, glitch);
    nw = (rej || tmo) ? 0 : (rd ? len : 1);
    if (rej) begin
      sub_status = 4'b1000;
      sub_data   = $urandom;
    end
    send_words(nw);
    ok = 0;
    saw = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      saw |= sub_ready;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (rej) begin
      chk("ur_no_sub_ready", 64'(saw), 64'd0);
      @(posedge clk); #1;
      sub_status = 4'h0;
    end
    chk("txn_done", 64'(ok), 64'd1);
    if (!ok) begin
      do_reset();
    end else begin
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic fill_words(input int n, input bit allow_zero);
    cur_words.delete();
    for (int i = 0; i < n; i++)
      cur_words.push_back((allow_zero && $urandom_range(0, 3) == 0)
                          ? 32'h0 : $urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd;
    bit rej;
    bit tmo;
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sub_ready", 64'(sub_ready), 64'd0);
    chk("rst_out_tlp", 64'(out_tlp), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    cur_words.delete();
    cur_words.push_back(32'hFFFF0000);
    cur_words.push_back(32'hFFFEFFFF);
    run_txn(1, 2, 16'h0200, 8'h05, 0, 0, 0);

    cur_words.delete();
    cur_words.push_back(32'h0);
    run_txn(0, 1, 16'h1234, 8'hA5, 0, 0, 0);

    fill_words(20, 0);
    run_txn(1, 20, 16'h0300, 8'h11, 0, 0, 0);

    fill_words(3, 0);
    run_txn(1, 3, 16'h0400, 8'h22, 1, 0, 0);

    fill_words(4, 0);
    run_txn(1, 4, 16'hBEEF, 8'h7E, 0, 1, 0);

    for (int t = 0; t < 40; t++) begin
      rd = ($urandom_range(0, 2) != 0);
      if (rd)
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20)
                                          : $urandom_range(1, 16);
      else
        len = $urandom_range(0, 20);
      rej = rd && (len == 0 || len > 16);
      tmo = !rej && ($urandom_range(0, 11) == 0);
      fill_words((len > 0) ? len : 1, 1);
      run_txn(rd, len, 16'($urandom), 8'($urandom), tmo,
              $urandom_range(0, 2), 1'($urandom));
    end

    or_mode = 0;
    fill_words(8, 0);
    push_expected(1, 8, 16'h0A0B, 8'h33, 0);
    issue(1, 8, 16'h0A0B, 8'h33, 0);
    send_words(8);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sub_ready", 64'(sub_ready), 64'd0);

    fill_words(5, 1);
    run_txn(1, 5, 16'h5566, 8'h44, 0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tlp_completion_builder.md
Name: tlp_completion_builder

Overview:
Downstream neighbour of the TLP request subunit. Drives the subunit's next_ready and captures each completion word it produces (out_data / completion_status). Collects the payload for one outstanding request and emits a PCIe completion TLP (Cpl or CplD) as a stream of 35-bit DW beats on a valid/ready interface toward the transmit path. Aborts with a Completer Abort completion on timeout.

Parameters:
MAX_LEN, 16, payload buffer depth in DWs; req_len above this is rejected
TIMEOUT, 255, max cycles in COLLECT with no captured word before abort
COMPLETER_ID, 16'h0100, value placed in DW1[31:16]

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request descriptor valid
req_ready  output  1  high only in IDLE
req_len  input  10  expected payload DWs (reads)
req_is_read  input  1  1 = memory read (CplD), 0 = write/IO/config (Cpl)
req_id  input  16  requester ID for DW2
req_tag  input  8  tag for DW2
sub_data  input  32  subunit out_data
sub_status  input  4  subunit completion_status; 4'b1000 = word valid
sub_ready  output  1  to subunit next_ready
out_tlp  output  35  [31:0] DW, [32] sop, [33] eop, [34] parity/0
out_valid  output  1  beat valid
out_ready  input  1  downstream accept
busy  output  1  state != IDLE

Behaviour:
- Single clock; reset is synchronous and active-high, named clk and reset. Reset, including mid-packet, yields state IDLE. All outputs go to 0 except req_ready, which is 1. Buffer count, timeout counter and status also clear.
- States: IDLE, COLLECT, HDR0, HDR1, HDR2, DATA.
- IDLE: on req_valid, latch the descriptor.
  - If req_is_read and (req_len == 0 or req_len > MAX_LEN): status = UR (3'b001), go to HDR0 with no data.
  - Otherwise: status = SC (3'b000), go to COLLECT.
- COLLECT, sub_ready:
  - High, except low for exactly one cycle after each capture. This ack pulse makes the subunit clear its output.
  - Low in every other state.
- COLLECT, capture: when sub_ready == 1 and sub_status == 4'b1000.
  - Read: write sub_data to buf[count], count++. sub_data == 0 is still a valid word. When count reaches req_len, go to HDR0 on the next cycle.
  - Non-read: the first capture completes the request; data is discarded; go to HDR0.
- Timeout counter:
  - Resets on each capture and increments otherwise.
  - At TIMEOUT: status = CA (3'b100), discard buffer, emit a Cpl with no data, go to HDR0.
- Beat advance: only on out_valid && out_ready. While out_ready == 0, out_tlp is held stable.
- Header DWs:
  - HDR0: DW = {fmt_type, 14'b0, len}. fmt_type is 8'h4A for CplD (read, SC) and 8'h0A for Cpl otherwise. len = req_len for CplD, else 0.
  - HDR1: DW = {COMPLETER_ID, status, 1'b0, byte_count[11:0]}. byte_count = req_len*4 for CplD, else 0.
  - HDR2: DW = {req_id, req_tag, 1'b0, 7'b0}.
- Framing:
  - sop = 1 on HDR0 only.
  - eop = 1 on HDR2 if no data, else on the last DATA beat.
  - DATA streams buf[0..req_len-1] in order.
- Return to IDLE after the eop beat is accepted. req_ready goes high the following cycle.
- Latency: HDR0 is valid on the cycle after the last capture. With out_ready held high, a CplD takes 3 + req_len cycles.
- Simultaneous events:
  - req_valid outside IDLE is ignored.
  - A sub_status pulse outside COLLECT is ignored.
  - A timeout in the same cycle as a capture counts as the capture.

Optional Feature:
CPL_PARITY_EN: when defined, out_tlp[34] = even parity (XOR reduction) of out_tlp[31:0] on every beat. When undefined, out_tlp[34] is constant 0.

Test Plan:
- Reset mid-DATA with out_ready = 1 → next cycle: out_valid = 0, req_ready = 1, busy = 0, sub_ready = 0.
- Read, req_len = 2, tag 8'h05, req_id 16'h0200; subunit returns 32'hFFFF0000 then 32'hFFFEFFFF → beats 32'h4A000002 (sop), 32'h01000008, 32'h02000500, 32'hFFFF0000, 32'hFFFEFFFF (eop). sub_ready must drop for one cycle after each capture.
- Write request; subunit returns data 0, status 4'b1000 → beats 32'h0A000000, 32'h01000000, {req_id, req_tag, 8'h00} with eop on the third beat.
- Read with req_len = 20 (> MAX_LEN) → no COLLECT; sub_ready stays 0; DW1 = 32'h01002000 (UR), eop on HDR2.
- Read with no subunit response → after 255 cycles in COLLECT, Cpl emitted with DW1[15:13] = 3'b100 and eop on HDR2.
- Toggle out_ready 0/1 every cycle during a 4-DW CplD → out_tlp stable while out_ready = 0; all 7 beats arrive in order. With CPL_PARITY_EN defined, bit 34 matches XOR of bits 31:0 on every beat.
